// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM stream reader and its output buffer.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo2_reg.sv
// Two-entry register FIFO. The head is held in a register so the output data
// never sees a combinational path from the write port.
module fifo2_reg
  import rom_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid
);

  logic [W-1:0]     r_head;
  logic [W-1:0]     r_tail;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == '0) r_head <= i_din;
          else               r_tail <= i_din;
          r_count <= r_count + CNT_W'(1);
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - CNT_W'(1);
        end
        2'b11: begin
          // Pop implies non-empty, so the count is either one or two here.
          if (r_count == CNT_W'(1)) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range, one read per cycle, and returns the
// words as a valid/ready stream with credit-based flow control.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  localparam int LW = ADDR_WIDTH + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_last;
  logic [LW-1:0]         r_left;
  logic                  r_inflight;
  logic [CNT_W-1:0]      w_count;
  logic [2:0]            w_occ;
  logic                  w_pop;
  logic                  w_issue;

  assign w_pop = m_valid_o & m_ready_i;
  // Buffer slots already spoken for after this cycle's pop; never exceeds depth.
  assign w_occ = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == RUN) && (r_left != '0) && (w_occ < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_addr_last <= '0;
      r_left      <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (r_state == IDLE && start_i) begin
        r_addr <= base_addr_i;
        r_left <= length_i;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_left      <= r_left - LW'(1);
        r_addr_last <= r_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start_i) w_state_nxt = (length_i == '0) ? DONE : RUN;
      RUN:   if ((r_left == '0) || (w_issue && r_left == LW'(1))) w_state_nxt = DRAIN;
      DRAIN: if (!r_inflight && ((w_count == '0) || (w_count == CNT_W'(1) && w_pop)))
               w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  fifo2_reg #(.W(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_din   (rom_data_i),
    .i_pop   (w_pop),
    .o_head  (m_data_o),
    .o_count (w_count),
    .o_valid (m_valid_o)
  );

  assign rom_addr_o = w_issue ? r_addr : r_addr_last;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized and directed bench for rom_stream_reader against a word-list model.
module tb_rom_stream_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   length_i = '0;
  logic          busy_o, done_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] rom_mem [16];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) rom_mem[i] = 8'hA0 + 8'(i);

  always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

  rom_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return (c <= 0) || ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // mode 0: ready always high, full cycle-exact timing checked.
  task automatic run(input logic [AW-1:0] base, input int len, input int mode, input bit mid_start);
    logic [DW-1:0] q[$];
    logic [AW-1:0] addr0;
    logic [DW-1:0] prev_data;
    int done_cyc, last_hs, a;
    bit seen_valid, prev_stall;
    for (int k = 0; k < len; k++) q.push_back(8'hA0 + 8'((int'(base) + k) % 16));
    @(posedge clk); #1;
    addr0 = rom_addr_o;
    start_i = 1'b1; base_addr_i = base; length_i = 5'(len);
    m_ready_i = rdy(mode, 0);
    done_cyc = -1; last_hs = -1; seen_valid = 0; prev_stall = 0; prev_data = '0;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start_i = mid_start && (c == 2);
      base_addr_i = base + 4'd7;
      length_i = 5'd3;
      m_ready_i = rdy(mode, c);
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, prev_data);
      end
      if (mode == 0) begin
        chk("valid", m_valid_o, (len > 0) && (c >= 3) && (c <= len + 2));
        chk("done", done_o, (len == 0) ? (c == 1) : (c == len + 3));
        chk("busy", busy_o, (len == 0) ? (c == 1) : (c <= len + 3));
        if (len == 0) chk("addr_idle", rom_addr_o, addr0);
        else begin
          a = (int'(base) + ((c <= len) ? c - 1 : len - 1)) % 16;
          chk("addr", rom_addr_o, a);
        end
      end else begin
        chk("busy", busy_o, 1);
      end
      if (m_valid_o) seen_valid = 1;
      if (m_valid_o && m_ready_i) begin
        if (q.size() == 0) chk("extra_beat", m_data_o, 'hFFFF);
        else chk("data", m_data_o, q.pop_front());
        last_hs = c;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      if (done_o) done_cyc = c;
    end
    start_i = 1'b0;
    if (done_cyc < 0) chk("timeout", 0, 1);
    chk("words_left", q.size(), 0);
    if (len == 0) begin
      chk("done_cyc0", done_cyc, 1);
      chk("no_valid", seen_valid, 0);
      chk("addr_unchanged", rom_addr_o, addr0);
    end else begin
      chk("done_after_last", done_cyc, last_hs + 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
  endtask

  task automatic abort_test();
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 4'd5; length_i = 5'd8; m_ready_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_valid", m_valid_o, 0);
    chk("abort_data", m_data_o, 0);
    chk("abort_addr", rom_addr_o, 0);
    repeat (4) begin
      @(negedge clk);
      chk("post_abort_done", done_o, 0);
      chk("post_abort_valid", m_valid_o, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_addr", rom_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(4'd3, 5, 0, 0);
    run(4'd14, 4, 0, 0);
    run(4'd0, 0, 0, 0);
    run(4'd0, 16, 1, 0);
    run(4'd9, 7, 0, 1);
    abort_test();
    run(4'd5, 8, 0, 0);
    run(4'd0, 16, 0, 0);
    for (int i = 0; i < 20; i++)
      run(4'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
          int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
